miner_scheduler: RTL

Work scheduler for the hashing cores of the Mojo v3 miner. It accepts one work unit from the host link and splits the nonce space evenly across NUM_CORES cores, then starts them. It collects found nonces through a round-robin arbiter into a single-entry result register and emits the one-cycle `new_work` / `new_result` pulses that drive the LED status handler.

---
 rtl/miner_scheduler.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/miner_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : miner_scheduler
//  Description : Accepts one work unit, splits the nonce space evenly across
//                NUM_CORES hashing cores, starts them, and collects found
//                nonces through a round-robin arbiter into a single-entry
//                result register. Emits new_work / new_result status pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
module miner_scheduler #(
  parameter int NUM_CORES = 4,
  parameter int NONCE_W   = 32,
  parameter int WORK_W    = 352,
  parameter int CNT_W     = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         work_valid,
  input  logic [WORK_W-1:0]            work_data,
  output logic                         work_ready,
  output logic [WORK_W-1:0]            core_work,
  output logic [NUM_CORES*NONCE_W-1:0] core_nonce_start,
  output logic [NUM_CORES-1:0]         core_start,
  input  logic [NUM_CORES-1:0]         core_done,
  input  logic [NUM_CORES-1:0]         core_found,
  input  logic [NUM_CORES*NONCE_W-1:0] core_found_nonce,
  output logic [NUM_CORES-1:0]         core_found_ack,
  output logic                         result_valid,
  output logic [NONCE_W-1:0]           result_nonce,
  input  logic                         result_ready,
  output logic [CNT_W-1:0]             result_count,
  output logic                         new_work,
  output logic                         new_result,
  output logic                         busy
);

  localparam int c_LOG2N = $clog2(NUM_CORES);
  localparam int c_PTR_W = (NUM_CORES > 1) ? c_LOG2N : 1;
  localparam int c_SHIFT = NONCE_W - c_LOG2N;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_DISPATCH = 2'd1,
    S_RUN      = 2'd2
  } state_t;

  state_t                         r_state;
  logic [1:0]                     r_guard;
  logic [c_PTR_W-1:0]             r_rr;
  logic [WORK_W-1:0]              r_core_work;
  logic [NUM_CORES*NONCE_W-1:0]   r_nonce_start;
  logic [NUM_CORES-1:0]           r_core_start;
  logic                           r_result_valid;
  logic [NONCE_W-1:0]             r_result_nonce;
  logic [CNT_W-1:0]               r_result_count;
  logic                           r_new_work;
  logic                           r_new_result;

  logic                           w_work_ready;
  logic                           w_accept;
  logic                           w_slot_free;
  logic                           w_any_found;
  logic [c_PTR_W-1:0]             w_grant_idx;
  logic [NONCE_W-1:0]             w_grant_nonce;
  logic                           w_grant;
  logic                           w_exit;
  logic [NUM_CORES*NONCE_W-1:0]   w_nonce_start;

  // Each core gets an equal slice: core i starts at i * 2^NONCE_W / NUM_CORES
  for (genvar i = 0; i < NUM_CORES; i++) begin : g_nonce_start
    assign w_nonce_start[i*NONCE_W +: NONCE_W] = NONCE_W'(i) << c_SHIFT;
  end

  assign w_work_ready = (r_state != S_DISPATCH);
  assign w_accept     = work_valid & w_work_ready;
  assign w_slot_free  = ~r_result_valid | result_ready;

  // Round-robin search: first found core at or after the pointer, wrapping
  always_comb begin
    w_any_found   = 1'b0;
    w_grant_idx   = '0;
    w_grant_nonce = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      int idx;
      idx = (int'(r_rr) + k) % NUM_CORES;
      if (!w_any_found && core_found[idx]) begin
        w_any_found   = 1'b1;
        w_grant_idx   = c_PTR_W'(idx);
        w_grant_nonce = core_found_nonce[idx*NONCE_W +: NONCE_W];
      end
    end
  end

  // A new accept preempts arbitration so stale finds of the old work are dropped
  assign w_grant = (r_state == S_RUN) & w_slot_free & ~w_accept & w_any_found;
  assign w_exit  = (r_guard == 2'd0) & (&core_done) & ~(|core_found) & ~w_accept;

  assign core_found_ack = w_grant ? (NUM_CORES'(1) << w_grant_idx) : '0;

  // Scheduler state, result register and registered status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_guard        <= 2'd0;
      r_rr           <= '0;
      r_core_work    <= '0;
      r_nonce_start  <= '0;
      r_core_start   <= '0;
      r_result_valid <= 1'b0;
      r_result_nonce <= '0;
      r_result_count <= '0;
      r_new_work     <= 1'b0;
      r_new_result   <= 1'b0;
    end else begin
      r_core_start <= '0;
      r_new_work   <= 1'b0;
      r_new_result <= w_grant;

      if (w_grant) begin
        r_result_valid <= 1'b1;
        r_result_nonce <= w_grant_nonce;
        r_rr           <= c_PTR_W'((int'(w_grant_idx) + 1) % NUM_CORES);
        if (r_result_count != {CNT_W{1'b1}}) begin
          r_result_count <= r_result_count + 1'b1;
        end
      end else if (result_ready) begin
        r_result_valid <= 1'b0;
      end

      case (r_state)
        S_DISPATCH: begin
          r_guard <= 2'd2;
          r_state <= S_RUN;
        end
        S_RUN: begin
          if (r_guard != 2'd0) begin
            r_guard <= r_guard - 2'd1;
          end
          if (w_exit) begin
            r_state <= S_IDLE;
          end
        end
        default: ;
      endcase

      // Accept overrides the state update above and restarts every core
      if (w_accept) begin
        r_core_work    <= work_data;
        r_nonce_start  <= w_nonce_start;
        r_result_count <= '0;
        r_core_start   <= '1;
        r_new_work     <= 1'b1;
        r_state        <= S_DISPATCH;
      end
    end
  end

  assign work_ready       = w_work_ready;
  assign core_work        = r_core_work;
  assign core_nonce_start = r_nonce_start;
  assign core_start       = r_core_start;
  assign result_valid     = r_result_valid;
  assign result_nonce     = r_result_nonce;
  assign result_count     = r_result_count;
  assign new_work         = r_new_work;
  assign new_result       = r_new_result;
  assign busy             = (r_state != S_IDLE);

endmodule
`default_nettype wire
